// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access sequencer.
// Contents: FSM state encoding, frame length, address width, read-fill byte
// and the helper that selects a frame byte from a latched command.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTx     = 2'd1,
        StWaitRx = 2'd2,
        StRsp    = 2'd3
    } state_e;

    localparam int unsigned SPI_REG_FRAME_BYTES = 3;
    localparam int unsigned SPI_REG_ADDR_W      = 15;
    localparam logic [7:0]  SPI_REG_READ_FILL   = 8'h00;

    // Frame: {rnw, addr[14:8]}, addr[7:0], then wdata (writes) or fill (reads).
    function automatic logic [7:0] frame_byte(input logic                      rnw,
                                              input logic [SPI_REG_ADDR_W-1:0] addr,
                                              input logic [7:0]                wdata,
                                              input logic [1:0]                idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {rnw, addr[SPI_REG_ADDR_W-1:8]};
            2'd1:    b = addr[7:0];
            default: b = rnw ? SPI_REG_READ_FILL : wdata;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// Bus bundle for spi_reg_sequencer.
// Groups the command channel (s_cmd_*), response channel (m_rsp_*), the tx
// byte stream to the SPI master (m_axis_*) and the rx byte stream from it
// (s_axis_*). Modport slave is the sequencer's view; modport master is the
// view of the environment that issues commands and models the SPI master.
interface spi_reg_sequencer_if;
    import spi_reg_pkg::*;

    logic                      s_cmd_valid;
    logic                      s_cmd_ready;
    logic                      s_cmd_rnw;
    logic [SPI_REG_ADDR_W-1:0] s_cmd_addr;
    logic [7:0]                s_cmd_wdata;
    logic                      m_rsp_valid;
    logic                      m_rsp_ready;
    logic [7:0]                m_rsp_rdata;
    logic                      m_rsp_err;
    logic [7:0]                m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [7:0]                s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;

    modport master (
        output s_cmd_valid, s_cmd_rnw, s_cmd_addr, s_cmd_wdata, m_rsp_ready,
               m_axis_tready, s_axis_tdata, s_axis_tvalid,
        input  s_cmd_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, m_axis_tdata,
               m_axis_tvalid, s_axis_tready
    );

    modport slave (
        input  s_cmd_valid, s_cmd_rnw, s_cmd_addr, s_cmd_wdata, m_rsp_ready,
               m_axis_tready, s_axis_tdata, s_axis_tvalid,
        output s_cmd_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, m_axis_tdata,
               m_axis_tvalid, s_axis_tready
    );

endinterface

// File: rtl/spi_reg_sequencer.sv
// Register-access sequencer in front of an AXI-Stream SPI master.
// Takes one read/write command at a time, sends it as a 3-byte frame on the tx
// stream, counts the 3 returned rx bytes (keeping the third as read data) and
// issues one response per command.
// Ports:
//   aclk    - clock, rising edge
//   aresetn - asynchronous active-low reset
//   bus     - spi_reg_sequencer_if.slave: s_cmd_*, m_rsp_*, m_axis_* (tx), s_axis_* (rx)
// Build option: SPI_REG_SEQ_TIMEOUT_EN adds a WAIT_RX timeout of TIMEOUT_CYCLES
// cycles without an rx byte, answered with err=1 and rdata=0x00. Without it
// m_rsp_err is tied low and WAIT_RX waits indefinitely.
// Every output comes straight from a flop.
module spi_reg_sequencer
    import spi_reg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                aclk,
    input logic                aresetn,
    spi_reg_sequencer_if.slave bus
);

    localparam logic [1:0] CntDone = 2'(SPI_REG_FRAME_BYTES);
    localparam logic [1:0] CntLast = 2'(SPI_REG_FRAME_BYTES - 1);

    state_e                    state_q, state_d;
    logic [1:0]                tx_cnt_q, tx_cnt_d;
    logic [1:0]                rx_cnt_q, rx_cnt_d;
    logic                      rnw_q, rnw_d;
    logic [SPI_REG_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [7:0]                rdata_q, rdata_d;
    logic [7:0]                tdata_q, tdata_d;
    logic                      cmd_ready_q, tvalid_q, rsp_valid_q, rx_ready_q;
    logic                      cmd_hs, tx_hs, rx_hs, rsp_hs;

`ifdef SPI_REG_SEQ_TIMEOUT_EN
    localparam int unsigned     TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    logic [TimerW-1:0] timer_q, timer_d;
    logic              err_q, err_d;
    logic              timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign cmd_hs = bus.s_cmd_valid & cmd_ready_q;
    assign tx_hs  = tvalid_q & bus.m_axis_tready;
    assign rx_hs  = bus.s_axis_tvalid & rx_ready_q;
    assign rsp_hs = rsp_valid_q & bus.m_rsp_ready;

    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tdata_d  = tdata_q;
`ifdef SPI_REG_SEQ_TIMEOUT_EN
        err_d    = err_q;
        timer_d  = timer_q;
        timeout  = 1'b0;
`endif

        // Rx is only counted while a frame is in flight; it may run ahead of tx.
        if (rx_hs && (state_q == StTx || state_q == StWaitRx) && rx_cnt_q != CntDone) begin
            rx_cnt_d = rx_cnt_q + 2'd1;
            if (rx_cnt_q == CntLast) begin
                rdata_d = bus.s_axis_tdata;
            end
        end

`ifdef SPI_REG_SEQ_TIMEOUT_EN
        if (state_q == StWaitRx) begin
            if (rx_hs) begin
                timer_d = '0;
            end else if (timer_q == TimerLast) begin
                timeout = 1'b1;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    rnw_d    = bus.s_cmd_rnw;
                    addr_d   = bus.s_cmd_addr;
                    wdata_d  = bus.s_cmd_wdata;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    rdata_d  = SPI_REG_READ_FILL;
`ifdef SPI_REG_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
                    timer_d  = '0;
`endif
                    state_d  = StTx;
                end
            end
            StTx: begin
                if (tx_hs) begin
                    if (tx_cnt_q != CntDone) begin
                        tx_cnt_d = tx_cnt_q + 2'd1;
                    end
                    if (tx_cnt_q == CntLast) begin
                        state_d = (rx_cnt_d == CntDone) ? StRsp : StWaitRx;
                    end
                end
            end
            StWaitRx: begin
                if (rx_cnt_d == CntDone) begin
                    state_d = StRsp;
`ifdef SPI_REG_SEQ_TIMEOUT_EN
                end else if (timeout) begin
                    // rdata still holds the read-fill byte since byte2 never arrived
                    err_d   = 1'b1;
                    state_d = StRsp;
`endif
                end
            end
            StRsp: begin
                if (rsp_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Byte is a function of the latched command and tx_cnt, so it is stable under stall.
        if (state_d == StTx) begin
            tdata_d = frame_byte(rnw_d, addr_d, wdata_d, tx_cnt_d);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= SPI_REG_READ_FILL;
            tdata_q     <= 8'h00;
            cmd_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tdata_q     <= tdata_d;
            cmd_ready_q <= (state_d == StIdle);
            tvalid_q    <= (state_d == StTx);
            rsp_valid_q <= (state_d == StRsp);
            rx_ready_q  <= 1'b1;
        end
    end

`ifdef SPI_REG_SEQ_TIMEOUT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_rsp_err = err_q;
`else
    assign bus.m_rsp_err = 1'b0;
`endif

    assign bus.s_cmd_ready   = cmd_ready_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_rsp_valid   = rsp_valid_q;
    assign bus.m_rsp_rdata   = rdata_q;
    assign bus.s_axis_tready = rx_ready_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Self-checking bench for spi_reg_sequencer.
// Expected tx bytes and responses are queued when a command is issued and
// compared when the DUT hands them over; the rx side echoes a per-command byte
// table one cycle after each tx byte. Timeout scenario only with
// SPI_REG_SEQ_TIMEOUT_EN.
module tb_spi_reg_sequencer;

    localparam int unsigned TimeoutCycles = 16;

    logic aclk = 1'b0;
    logic aresetn;

    spi_reg_sequencer_if bus ();

    spi_reg_sequencer #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] tx_exp[$];
    int         tx_rd = 0;
    logic [8:0] rsp_exp[$];        // {err, rdata}
    int         rsp_rd = 0;
    logic [7:0] rx_pending[$];
    int         rx_rd = 0;
    logic [7:0] rx_src[3];
    int         rx_limit = 3;
    int         tx_idx = 0;
    int         tx_hs_cyc[3];
    int         last_evt = 0;
    int         rise_cyc = 0;
    logic       stray_req = 1'b0;
    logic       stray_ack = 1'b0;
    logic [7:0] stray_byte = 8'h00;
    logic       tx_stall = 1'b0;
    logic [7:0] tx_hold = 8'h00;
    logic       rsp_stall = 1'b0;
    logic [8:0] rsp_hold = 9'h0;
    logic       prev_rsp_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            tx_rd          = tx_exp.size();
            rsp_rd         = rsp_exp.size();
            tx_stall       = 1'b0;
            rsp_stall      = 1'b0;
            prev_rsp_valid = 1'b0;
            tx_idx         = 0;
        end else begin
            if (bus.s_cmd_valid && bus.s_cmd_ready) tx_idx = 0;

            if (tx_stall && bus.m_axis_tvalid) chk("tx_hold", bus.m_axis_tdata, tx_hold);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (tx_rd < tx_exp.size()) begin
                    chk("tx_byte", bus.m_axis_tdata, tx_exp[tx_rd]);
                    tx_rd++;
                end else begin
                    chk("tx_extra", tx_rd, tx_exp.size());
                end
                if (tx_idx < 3) begin
                    tx_hs_cyc[tx_idx] = cyc + 1;
                    if (tx_idx < rx_limit) rx_pending.push_back(rx_src[tx_idx]);
                    if (tx_idx == 2) last_evt = cyc + 1;
                    tx_idx++;
                end
            end
            tx_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            if (tx_stall) begin
                tx_hold = bus.m_axis_tdata;
                chk("cmd_ready_tx_busy", bus.s_cmd_ready, 0);
            end

            if (bus.s_axis_tvalid && bus.s_axis_tready) last_evt = cyc + 1;

            if (bus.m_rsp_valid && !prev_rsp_valid) rise_cyc = cyc;
            if (rsp_stall && bus.m_rsp_valid) chk("rsp_hold", {bus.m_rsp_err, bus.m_rsp_rdata}, rsp_hold);
            if (bus.m_rsp_valid && bus.m_rsp_ready) begin
                if (rsp_rd < rsp_exp.size()) begin
                    chk("rsp", {bus.m_rsp_err, bus.m_rsp_rdata}, rsp_exp[rsp_rd]);
                    rsp_rd++;
                end else begin
                    chk("rsp_extra", rsp_rd, rsp_exp.size());
                end
            end
            rsp_stall = bus.m_rsp_valid && !bus.m_rsp_ready;
            if (rsp_stall) begin
                rsp_hold = {bus.m_rsp_err, bus.m_rsp_rdata};
                chk("cmd_ready_rsp_busy", bus.s_cmd_ready, 0);
            end
            prev_rsp_valid = bus.m_rsp_valid;
        end
    end

    // Rx driver: one byte per cycle from the pending table, or a stray byte on request.
    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                rx_rd             = rx_pending.size();
                bus.s_axis_tvalid = 1'b0;
            end else if (stray_req != stray_ack) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = stray_byte;
                stray_ack         = stray_req;
            end else if (rx_rd < rx_pending.size()) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = rx_pending[rx_rd];
                rx_rd++;
            end else begin
                bus.s_axis_tvalid = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic rnw, input logic [14:0] addr, input logic [7:0] wdata,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] exp_rdata, input logic exp_err);
        bit ok = 1'b0;
        tx_exp.push_back(b0);
        tx_exp.push_back(b1);
        tx_exp.push_back(b2);
        rsp_exp.push_back({exp_err, exp_rdata});
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_rnw   = rnw;
        bus.s_cmd_addr  = addr;
        bus.s_cmd_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.s_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge aclk);
        #1;
        bus.s_cmd_valid = 1'b0;
        chk("accept_tvalid", bus.m_axis_tvalid, 1);
        chk("accept_byte0", bus.m_axis_tdata, b0);
    endtask

    task automatic wait_rsp(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge aclk);
            #2;
            if (rsp_rd == rsp_exp.size()) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_rsp_done"}, done, 1);
        chk({tag, "_cmd_ready_next"}, bus.s_cmd_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, bus.s_cmd_ready, 0);
        chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        chk({tag, "_tdata"}, bus.m_axis_tdata, 0);
        chk({tag, "_rsp_valid"}, bus.m_rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, bus.m_rsp_rdata, 0);
        chk({tag, "_rsp_err"}, bus.m_rsp_err, 0);
        chk({tag, "_rx_ready"}, bus.s_axis_tready, 0);
    endtask

    initial begin
        bit seen = 1'b0;
        aresetn           = 1'b0;
        bus.s_cmd_valid   = 1'b0;
        bus.s_cmd_rnw     = 1'b0;
        bus.s_cmd_addr    = '0;
        bus.s_cmd_wdata   = '0;
        bus.m_rsp_ready   = 1'b1;
        bus.m_axis_tready = 1'b1;

        #12;
        check_reset_outputs("por");
        aresetn = 1'b1;
        @(posedge aclk);
        #2;
        chk("release_cmd_ready", bus.s_cmd_ready, 1);
        chk("release_rx_ready", bus.s_axis_tready, 1);

        // Write with rx echo.
        rx_src = '{8'h12, 8'h34, 8'hA5};
        send_cmd(1'b0, 15'h1234, 8'hA5, 8'h12, 8'h34, 8'hA5, 8'hA5, 1'b0);
        wait_rsp("wr");
        chk("wr_no_bubbles", tx_hs_cyc[2] - tx_hs_cyc[0], 2);

        // Read.
        rx_src = '{8'hFF, 8'hFF, 8'h3C};
        send_cmd(1'b1, 15'h7F01, 8'hEE, 8'hFF, 8'h01, 8'h00, 8'h3C, 1'b0);
        wait_rsp("rd");

        // Backpressure on tx and response.
        bus.m_rsp_ready = 1'b0;
        rx_src = '{8'h0A, 8'hBC, 8'h5A};
        send_cmd(1'b0, 15'h0ABC, 8'h5A, 8'h0A, 8'hBC, 8'h5A, 8'h5A, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(posedge aclk);
            #2;
            bus.m_axis_tready = ~bus.m_axis_tready;
            if (tx_rd == tx_exp.size()) break;
        end
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.m_rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge aclk);
            #2;
        end
        chk("bp_rsp_seen", seen, 1);
        repeat (5) @(posedge aclk);
        #2;
        bus.m_rsp_ready = 1'b1;
        wait_rsp("bp");

        // Stray rx byte while idle must be dropped.
        stray_byte = 8'h55;
        stray_req  = ~stray_req;
        repeat (3) @(posedge aclk);
        #2;
        rx_src = '{8'h11, 8'h22, 8'h99};
        send_cmd(1'b1, 15'h0042, 8'h00, 8'h80, 8'h42, 8'h00, 8'h99, 1'b0);
        wait_rsp("stray");

`ifdef SPI_REG_SEQ_TIMEOUT_EN
        // Only two rx bytes come back.
        rx_src   = '{8'h77, 8'h66, 8'h55};
        rx_limit = 2;
        send_cmd(1'b1, 15'h0100, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_rsp("to");
        chk("to_latency", rise_cyc - last_evt, TimeoutCycles);
        rx_limit = 3;
        rx_src   = '{8'h01, 8'h02, 8'hC3};
        send_cmd(1'b1, 15'h0102, 8'h00, 8'h81, 8'h02, 8'h00, 8'hC3, 1'b0);
        wait_rsp("after_to");
`endif

        // Reset while byte1 is stalled on the tx stream.
        bus.m_axis_tready = 1'b0;
        rx_src = '{8'h22, 8'h33, 8'h44};
        send_cmd(1'b0, 15'h2233, 8'h44, 8'h22, 8'h33, 8'h44, 8'h44, 1'b0);
        @(posedge aclk);
        #2;
        bus.m_axis_tready = 1'b1;
        @(posedge aclk);
        #2;
        bus.m_axis_tready = 1'b0;
        chk("pre_rst_byte1", bus.m_axis_tdata, 8'h33);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge aclk);
        #3;
        aresetn           = 1'b1;
        bus.m_axis_tready = 1'b1;
        @(posedge aclk);
        #2;
        chk("midrst_release_ready", bus.s_cmd_ready, 1);
        rx_src = '{8'h03, 8'h05, 8'h6D};
        send_cmd(1'b0, 15'h0305, 8'h6D, 8'h03, 8'h05, 8'h6D, 8'h6D, 1'b0);
        wait_rsp("post_rst");

        repeat (3) @(posedge aclk);
        #2;
        chk("tx_drain", tx_rd, tx_exp.size());
        chk("rsp_drain", rsp_rd, rsp_exp.size());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

Register-access sequencer that sits directly upstream of the AXI-Stream SPI master. It accepts one register read/write command at a time and serializes it into a fixed 3-byte frame on the SPI master's byte-wide transmit stream. It collects the 3 bytes returned on the SPI master's receive stream and issues one response per command, carrying read data and an error flag.

## Interface
- `TIMEOUT_CYCLES`, default 4096: aclk cycles allowed in WAIT_RX without an rx byte before the command aborts. Used only with the timeout feature; must be ≥ 2.
- `aclk`  in  1  sole clock; all logic rising-edge.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `s_cmd_valid`  in  1  command valid.
- `s_cmd_ready`  out  1  command accepted when valid & ready.
- `s_cmd_rnw`  in  1  1 = read, 0 = write.
- `s_cmd_addr`  in  15  register address.
- `s_cmd_wdata`  in  8  write data; ignored for reads.
- `m_rsp_valid`  out  1  response valid.
- `m_rsp_ready`  in  1  response consumed when valid & ready.
- `m_rsp_rdata`  out  8  third received byte; 0x00 on error.
- `m_rsp_err`  out  1  1 = timeout abort.
- `m_axis_tdata`  out  8  tx byte to SPI master.
- `m_axis_tvalid`  out  1  tx byte valid.
- `m_axis_tready`  in  1  SPI master accepts byte.
- `s_axis_tdata`  in  8  rx byte from SPI master.
- `s_axis_tvalid`  in  1  rx byte valid.
- `s_axis_tready`  out  1  constant 1 out of reset.

## Operation
- Frame bytes, in order:
  - byte0 = {rnw, addr[14:8]}
  - byte1 = addr[7:0]
  - byte2 = wdata for writes, 0x00 for reads.
- Rx bytes are counted 0..2 by `rx_cnt`; byte2 is latched as rdata. Bytes 0 and 1 are discarded.
- FSM:
  - IDLE: `s_cmd_ready`=1. On accept, latch the command, clear tx_cnt, rx_cnt and the timer, then go to TX.
  - TX: `m_axis_tvalid`=1 with the byte selected by tx_cnt. On handshake, tx_cnt++. After byte2's handshake: go to RSP if rx_cnt==3, else go to WAIT_RX.
  - WAIT_RX: wait for rx_cnt==3, then go to RSP.
  - RSP: `m_rsp_valid`=1. On handshake, go to IDLE.
- Rx bytes are accepted in every state. Rx bytes arriving in IDLE or RSP are dropped and do not change the counters. Rx bytes are counted in TX, so rx can overlap tx.
- tx_cnt and rx_cnt are 2 bits and saturate at 3. A 4th rx byte within one command is dropped.
- Outputs hold stable while valid and not ready, per AXI-Stream rules. tdata never changes while tvalid=1 and tready=0.
- Async reset mid-frame: every output takes its reset value immediately and the FSM returns to IDLE. No partial response is produced.

## Timing
- Reset values:
  - `s_cmd_ready`=0 during reset, then 1 in IDLE from the first clock after release.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0x00.
  - `m_rsp_valid`=0, `m_rsp_rdata`=0x00, `m_rsp_err`=0.
  - `s_axis_tready`=0 during reset, 1 after release.
- Command accepted at edge T: `m_axis_tvalid`=1 with byte0 from T+1.
- Back-to-back tx: byte n+1 is presented the cycle after byte n's handshake, so there are no tvalid bubbles.
- Response: `m_rsp_valid` rises the cycle after the state's last event. That event is byte2's tx handshake when rx is already done, otherwise the 3rd rx handshake.
- After the response handshake, `s_cmd_ready` rises the next cycle. Command-to-command minimum is therefore 1 idle cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SPI_REG_SEQ_TIMEOUT_EN` defined:
  - The WAIT_RX timer increments each cycle and clears on every rx handshake.
  - When the timer reaches `TIMEOUT_CYCLES`-1, the FSM goes to RSP with err=1 and rdata=0x00.
  - TX never times out, so no tvalid is ever withdrawn.
- `SPI_REG_SEQ_TIMEOUT_EN` undefined: there is no timer, `m_rsp_err` is tied to 0, and WAIT_RX waits indefinitely.

## Structure
- Shared package `spi_reg_pkg`:
  - state encoding (IDLE/TX/WAIT_RX/RSP)
  - frame length constant `SPI_REG_FRAME_BYTES`=3
  - address width 15
  - read-fill byte 0x00
- Single flat module; no sub-module. The timer is small enough to inline.

## Test plan
- Write: addr 0x1234, wdata 0xA5, tready=1, rx echoes 1 cycle later.
  - Tx must be 0x12, 0x34, 0xA5 on consecutive cycles.
  - Response: err=0, rdata=0xA5 (rx third byte).
- Read: addr 0x7F01, rx returns 0xFF, 0xFF, 0x3C.
  - Tx must be 0xFF, 0x01, 0x00.
  - Response: rdata=0x3C, err=0.
- Backpressure: tready toggles 1/0 every cycle, and m_rsp_ready=0 for 5 cycles.
  - tdata stable while stalled; each byte sent exactly once.
  - Response held stable until ready.
  - s_cmd_ready=0 throughout.
- Stray rx: one rx byte 0x55 injected in IDLE, then a read whose third rx byte is 0x99.
  - Response rdata=0x99.
- Timeout (with macro, TIMEOUT_CYCLES=16): only 2 rx bytes returned.
  - Response err=1, rdata=0x00, exactly 16 cycles after the last rx byte or tx completion.
  - Next command proceeds normally.
- aresetn pulsed low while TX is on byte1.
  - All outputs immediately at their reset values.
  - After release, a new write frame starts with byte0.
